// File: rtl/float_dec_seq.sv
// ---------------------------------------------------------------------------
// float_dec_seq
//
// Sequential float-to-unsigned decoder. Takes a normalised mantissa F and an
// exponent P (bit position of the leading one of the original value) and
// rebuilds U = F >> (UW-1-P), shifting right one bit per clock. F=0 decodes
// to U=0 for any P.
//
// Handshake: one word in flight at a time. A word is accepted in IDLE on
// in_valid & in_ready. The result is held in DONE until out_ready; the
// block then returns to IDLE before it accepts the next word.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (release synchronised outside)
//   in_valid   F/P valid
//   in_ready   decoder can accept F/P (high only in IDLE)
//   F          normalised mantissa, UW bits
//   P          exponent, PW bits
//   out_valid  U valid (high only in DONE)
//   out_ready  consumer accepts U
//   U          decoded value, UW bits (always the shift register contents)
//   err        non-normalised input flag
//
// Optional feature, enabled by defining FLOAT_DEC_CHECK_EN:
//   err is captured at the accept edge and held until the next accept or
//   reset. It flags F!=0 with F[UW-1]==0, F==0 with P!=0, or P > UW-1.
//   Decoding is unaffected. With the macro undefined, err is tied to 0.
// ---------------------------------------------------------------------------
module float_dec_seq #(
    parameter int UW = 4,
    parameter int PW = 2,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [UW-1:0] F,
    input  logic [PW-1:0] P,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [UW-1:0] U,
    output logic          err
);

    localparam int unsigned TOP = UW - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [UW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Shift count k = (P >= UW-1) ? 0 : UW-1-P.
    // It is computed at 32 bits so that an out-of-range P saturates to 0.
    logic [31:0]   p_ext;
    logic [31:0]   k_full;
    logic [CW-1:0] k;

    always_comb begin
        p_ext  = 32'(P);
        k_full = (p_ext >= TOP) ? 32'd0 : (TOP - p_ext);
        k      = k_full[CW-1:0];
    end

`ifdef FLOAT_DEC_CHECK_EN
    logic err_q, err_d;
    logic bad_in;

    always_comb begin
        bad_in = ((F != '0) && !F[UW-1]) ||
                 ((F == '0) && (P != '0)) ||
                 (p_ext > TOP);
    end
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef FLOAT_DEC_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = F;
                    cnt_d   = k;
`ifdef FLOAT_DEC_CHECK_EN
                    err_d   = bad_in;
`endif
                    state_d = (k == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                // This is the last shift: the counter goes 1 -> 0 now.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE costs one clock; no word is taken here.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FLOAT_DEC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign U         = shreg_q;

endmodule

// File: tb/tb_float_dec_seq.sv
// ---------------------------------------------------------------------------
// tb_float_dec_seq
//
// Bench for float_dec_seq with default parameters (UW=4, PW=2, CW=3).
// A transaction-level reference tracks, for each accepted word, the decoded
// value (F >> k), the flag value and the number of clocks until the result
// appears. A per-cycle compare process checks the DUT against it. Directed
// words also check hand-computed U, latency and err literals.
// Compile with FLOAT_DEC_CHECK_EN defined to check the flag.
// ---------------------------------------------------------------------------
module tb_float_dec_seq;

    localparam int UW = 4;
    localparam int PW = 2;
    localparam int CW = 3;

`ifdef FLOAT_DEC_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [UW-1:0] F = '0;
    logic [PW-1:0] P = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [UW-1:0] U;
    logic          err;

    int tests = 0;
    int fails = 0;

    float_dec_seq #(.UW(UW), .PW(PW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .P         (P),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .U         (U),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int shift_of(input int p);
        return (p >= UW - 1) ? 0 : (UW - 1 - p);
    endfunction

    function automatic logic flag_of(input int f, input int p);
        if (!CHECK_ON) return 1'b0;
        return ((f != 0) && (f < (1 << (UW - 1)))) || ((f == 0) && (p != 0)) || (p > UW - 1);
    endfunction

    logic          m_busy;
    int            m_wait;
    logic [UW-1:0] m_u;
    logic          m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_wait <= 0;
            m_u    <= '0;
            m_err  <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_wait <= shift_of(int'(P));
                m_u    <= UW'(int'(F) >> shift_of(int'(P)));
                m_err  <= flag_of(int'(F), int'(P));
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy));
            chk("cyc_out_valid", 32'(out_valid), 32'(m_busy && (m_wait == 0)));
            if (m_busy && (m_wait == 0)) chk("cyc_U", 32'(U), 32'(m_u));
            chk("cyc_err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    // Offers a word, waits for acceptance and for out_valid, then checks
    // U, latency (clocks counted including the accepting edge) and err.
    // Returns at the negedge where out_valid is first seen.
    task automatic send(input logic [UW-1:0] f, input logic [PW-1:0] p,
                        input logic [UW-1:0] exp_u, input int exp_lat, input logic exp_err);
        logic rdy;
        int   n;
        int   lat;
        @(posedge clk); #1;
        in_valid = 1'b1;
        F = f;
        P = p;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        in_valid = 1'b0;
        if (!rdy) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 50) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("lit_U", 32'(U), 32'(exp_u));
        chk("lit_latency", 32'(lat), 32'(exp_lat));
        chk("lit_err", 32'(err), 32'(exp_err));
        $display("[TB] word F=%b P=%0d -> U=%b lat=%0d err=%b", f, p, U, lat, err);
    endtask

    // After send() with out_ready=1: one clock later the block is idle again.
    task automatic expect_idle_next;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_U", 32'(U), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // k=3, k=2, k=0 paths
        send(4'b1000, 2'd0, 4'b0001, 4, 1'b0);
        expect_idle_next();
        send(4'b1110, 2'd2, 4'b0111, 2, 1'b0);
        expect_idle_next();
        send(4'b1100, 2'd3, 4'b1100, 1, 1'b0);
        expect_idle_next();
        send(4'b1011, 2'd1, 4'b0010, 3, 1'b0);
        expect_idle_next();

        // Zero mantissa
        send(4'b0000, 2'd0, 4'b0000, 4, 1'b0);
        expect_idle_next();

        // Backpressure: result and out_valid held, nothing accepted
        out_ready = 1'b0;
        send(4'b1010, 2'd3, 4'b1010, 1, 1'b0);
        in_valid = 1'b1;
        F = 4'b0110;
        P = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_U", 32'(U), 32'b1010);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        expect_idle_next();

        // Reset during SHIFT aborts the word
        @(posedge clk); #1;
        in_valid = 1'b1;
        F = 4'b1000;
        P = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_U", 32'(U), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'b1110, 2'd2, 4'b0111, 2, 1'b0);
        expect_idle_next();

        // Non-normalised input flag
        send(4'b0100, 2'd1, 4'b0001, 3, CHECK_ON);
        expect_idle_next();
        send(4'b1000, 2'd3, 4'b1000, 1, 1'b0);
        expect_idle_next();
        send(4'b0000, 2'd2, 4'b0000, 2, CHECK_ON);
        expect_idle_next();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
